gnn_0_example_save: RTL



---
 rtl/gnn_save_pkg.sv | 43 ++++
 rtl/gnn_0_example_save_if.sv | 36 +++
 rtl/gnn_save_skid_fifo.sv | 53 +++++
 rtl/gnn_0_example_save.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/gnn_save_pkg.sv
// Shared types and constants for the result-buffer save path: state encoding,
// instruction field positions (common with the bias/weight loaders) and beat payload.
package gnn_save_pkg;

    localparam int unsigned SAVE_INST_LENGTH   = 96;
    localparam int unsigned C_M_AXI_ADDR_WIDTH = 64;
    localparam int unsigned C_M_AXI_DATA_WIDTH = 512;
    localparam int unsigned C_XFER_SIZE_WIDTH  = 32;
    localparam int unsigned C_BUF_ADDR_WIDTH   = 9;

    localparam int unsigned INST_FIELD_WIDTH    = 16;
    localparam int unsigned INST_BUF_START_LSB  = 32;
    localparam int unsigned INST_ROW_COUNT_LSB  = 48;
    localparam int unsigned INST_DRAM_START_LSB = 64;
    localparam int unsigned INST_BYTE_LEN_LSB   = 80;

    localparam int unsigned FIFO_DEPTH     = 2;
    localparam int unsigned FIFO_CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        WAIT_WR,
        DONE
    } save_state_e;

    typedef logic [C_BUF_ADDR_WIDTH-1:0] buf_addr_t;

    typedef struct packed {
        logic                          last;
        logic [C_M_AXI_DATA_WIDTH-1:0] data;
    } save_beat_t;

    // Extract one 16-bit instruction field starting at lsb.
    function automatic logic [INST_FIELD_WIDTH-1:0] inst_field(
        input logic [SAVE_INST_LENGTH-1:0] inst,
        input int unsigned                 lsb
    );
        return inst[lsb +: INST_FIELD_WIDTH];
    endfunction

endpackage

// File: rtl/gnn_0_example_save_if.sv
// Save-to-write-master bundle: transfer descriptor, start/done handshake and beat stream.
interface gnn_0_example_save_if;
    import gnn_save_pkg::*;

    logic                          write_start;
    logic                          write_done;
    logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes;
    logic                          data_tvalid;
    logic                          data_tready;
    logic                          data_tlast;
    logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata;

    modport master (
        output write_start,
        output dram_xfer_start_addr,
        output dram_xfer_size_in_bytes,
        output data_tvalid,
        output data_tlast,
        output data_tdata,
        input  write_done,
        input  data_tready
    );

    modport slave (
        input  write_start,
        input  dram_xfer_start_addr,
        input  dram_xfer_size_in_bytes,
        input  data_tvalid,
        input  data_tlast,
        input  data_tdata,
        output write_done,
        output data_tready
    );

endinterface

// File: rtl/gnn_save_skid_fifo.sv
// Two-entry first-word-fall-through FIFO; entry 0 is always the head so the
// outgoing beat comes straight from a register.
module gnn_save_skid_fifo
    import gnn_save_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  save_beat_t                push_beat,
    input  logic                      pop,
    output logic [FIFO_CNT_WIDTH-1:0] count,
    output save_beat_t                head
);

    save_beat_t                entry_q [FIFO_DEPTH];
    logic [FIFO_CNT_WIDTH-1:0] cnt_q;
    logic [FIFO_CNT_WIDTH-1:0] cnt_after_pop_c;
    logic                      empty_c;
    logic                      full_c;
    logic                      pop_ok_c;
    logic                      push_ok_c;

    assign empty_c         = (cnt_q == '0);
    assign full_c          = (cnt_q == FIFO_CNT_WIDTH'(FIFO_DEPTH));
    assign pop_ok_c        = pop && !empty_c;
    assign push_ok_c       = push && (!full_c || pop_ok_c);
    assign cnt_after_pop_c = cnt_q - FIFO_CNT_WIDTH'(pop_ok_c);

    // Pop shifts entry 1 forward; a push lands in the first slot left free after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            cnt_q <= cnt_q + FIFO_CNT_WIDTH'(push_ok_c) - FIFO_CNT_WIDTH'(pop_ok_c);
            if (pop_ok_c) begin
                entry_q[0] <= entry_q[1];
            end
            if (push_ok_c) begin
                if (cnt_after_pop_c == '0) begin
                    entry_q[0] <= push_beat;
                end else begin
                    entry_q[1] <= push_beat;
                end
            end
        end
    end

    assign count = cnt_q;
    assign head  = entry_q[0];

endmodule

// File: rtl/gnn_0_example_save.sv
// Save engine: reads a contiguous range of result-buffer rows and streams them
// as beats to the AXI write master, then pulses ap_done once the write completes.
module gnn_0_example_save
    import gnn_save_pkg::*;
(
    input  logic                          kernel_clk,
    input  logic                          kernel_rst_n,
    input  logic                          ap_start,
    output logic                          ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [SAVE_INST_LENGTH-1:0]   ctrl_instruction,
    output logic                          save_read_buffer_a_en,
    output logic [C_BUF_ADDR_WIDTH-1:0]   save_read_buffer_a_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_a_data,
    gnn_0_example_save_if.master          wr
);

    localparam int unsigned OCC_WIDTH = FIFO_CNT_WIDTH + 1;

    save_state_e                   state_q, state_d;
    logic                          ap_done_q, ap_done_d;
    logic                          write_start_q, write_start_d;
    logic                          sticky_done_q, sticky_done_d;

    buf_addr_t                     buf_start_q;
    buf_addr_t                     row_cnt_q;
    buf_addr_t                     issue_cnt_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] xfer_addr_q;
    logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size_q;

    logic                          rd_pending_q;
    logic                          rd_pending_last_q;
    logic                          rd_en_c;
    logic                          rd_last_c;
    logic                          start_c;
    logic                          pop_c;
    logic [OCC_WIDTH-1:0]          occupancy_c;

    logic [FIFO_CNT_WIDTH-1:0]     fifo_cnt;
    save_beat_t                    fifo_head;
    save_beat_t                    push_beat;

    logic [INST_FIELD_WIDTH-1:0]   f_buf_start;
    logic [INST_FIELD_WIDTH-1:0]   f_row_cnt;
    logic [INST_FIELD_WIDTH-1:0]   f_dram_start;
    logic [INST_FIELD_WIDTH-1:0]   f_byte_len;
    logic                          unused_inst_bits;

    assign f_buf_start  = inst_field(ctrl_instruction, INST_BUF_START_LSB);
    assign f_row_cnt    = inst_field(ctrl_instruction, INST_ROW_COUNT_LSB);
    assign f_dram_start = inst_field(ctrl_instruction, INST_DRAM_START_LSB);
    assign f_byte_len   = inst_field(ctrl_instruction, INST_BYTE_LEN_LSB);

    // Only 9 bits of row address/count are meaningful for a 512-row buffer.
    assign unused_inst_bits = ^{ctrl_instruction[INST_BUF_START_LSB-1:0],
                                f_buf_start[INST_FIELD_WIDTH-1:C_BUF_ADDR_WIDTH],
                                f_row_cnt[INST_FIELD_WIDTH-1:C_BUF_ADDR_WIDTH]};

    assign start_c = (state_q == IDLE) && ap_start;
    assign pop_c   = (fifo_cnt != '0) && wr.data_tready;

    // Occupancy once this cycle's pop leaves and the read landing this cycle arrives.
    assign occupancy_c = OCC_WIDTH'(fifo_cnt) + OCC_WIDTH'(rd_pending_q) - OCC_WIDTH'(pop_c);
    assign rd_en_c     = (state_q == STREAM) && (issue_cnt_q != row_cnt_q)
                         && (occupancy_c < OCC_WIDTH'(FIFO_DEPTH));
    assign rd_last_c   = (issue_cnt_q == (row_cnt_q - buf_addr_t'(1)));

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            state_q       <= IDLE;
            ap_done_q     <= 1'b0;
            write_start_q <= 1'b0;
            sticky_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ap_done_q     <= ap_done_d;
            write_start_q <= write_start_d;
            sticky_done_q <= sticky_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        write_start_d = 1'b0;
        sticky_done_d = sticky_done_q;
        unique case (state_q)
            IDLE: begin
                sticky_done_d = 1'b0;
                if (ap_start) begin
                    state_d       = START;
                    write_start_d = (f_row_cnt[C_BUF_ADDR_WIDTH-1:0] != '0);
                end
            end
            START: begin
                state_d = (row_cnt_q == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (wr.write_done) begin
                    sticky_done_d = 1'b1;
                end
                if (pop_c && fifo_head.last) begin
                    state_d = WAIT_WR;
                end
            end
            WAIT_WR: begin
                if (wr.write_done || sticky_done_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ap_done_d = (state_d == DONE);
    end

    // Instruction latch; descriptor outputs hold until the next start.
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            buf_start_q <= '0;
            row_cnt_q   <= '0;
            xfer_addr_q <= '0;
            xfer_size_q <= '0;
        end else if (start_c) begin
            buf_start_q <= f_buf_start[C_BUF_ADDR_WIDTH-1:0];
            row_cnt_q   <= f_row_cnt[C_BUF_ADDR_WIDTH-1:0];
            xfer_addr_q <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(f_dram_start);
            xfer_size_q <= C_XFER_SIZE_WIDTH'(f_byte_len);
        end
    end

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            issue_cnt_q       <= '0;
            rd_pending_q      <= 1'b0;
            rd_pending_last_q <= 1'b0;
        end else begin
            if (start_c) begin
                issue_cnt_q <= '0;
            end else if (rd_en_c) begin
                issue_cnt_q <= issue_cnt_q + buf_addr_t'(1);
            end
            rd_pending_q      <= rd_en_c;
            rd_pending_last_q <= rd_en_c && rd_last_c;
        end
    end

    assign push_beat = '{last: rd_pending_last_q, data: save_read_buffer_a_data};

    gnn_save_skid_fifo u_fifo (
        .clk       (kernel_clk),
        .rst_n     (kernel_rst_n),
        .push      (rd_pending_q),
        .push_beat (push_beat),
        .pop       (pop_c),
        .count     (fifo_cnt),
        .head      (fifo_head)
    );

    assign ap_done                 = ap_done_q;
    assign save_read_buffer_a_en   = rd_en_c;
    assign save_read_buffer_a_addr = buf_start_q + issue_cnt_q;

    assign wr.write_start             = write_start_q;
    assign wr.dram_xfer_start_addr    = xfer_addr_q;
    assign wr.dram_xfer_size_in_bytes = xfer_size_q;
    assign wr.data_tvalid             = (fifo_cnt != '0);
    assign wr.data_tlast              = (fifo_cnt != '0) && fifo_head.last;
    assign wr.data_tdata              = fifo_head.data;

endmodule
